// File: rtl/rifl_fc_pkg.sv
// rifl_fc_pkg: shared definitions for the RIFL local flow-control generator.
//   FC_ON_KEY / FC_OFF_KEY : 8-bit control keys carried in the FC frame key field
//   META_CTRL              : meta field value marking a control frame
//   fc_state_e             : generator FSM states
//   build_fc_frame()       : builds a zeroed frame that carries only key and meta
package rifl_fc_pkg;

   localparam logic [7:0] FC_ON_KEY  = 8'h01;
   localparam logic [7:0] FC_OFF_KEY = 8'h02;
   localparam logic [1:0] META_CTRL  = 2'b00;

   // Upper bound on FRAME_WIDTH; callers cast the result down to their own width.
   localparam int unsigned MAX_FRAME_WIDTH = 1024;

   typedef enum logic [1:0] {
      IDLE_OFF = 2'd0,
      SEND_ON  = 2'd1,
      HOLD_ON  = 2'd2,
      SEND_OFF = 2'd3
   } fc_state_e;

   // Key sits just above the CRC field; meta is at [frame_width-3 -: 2].
   // Sync header and CRC are left zero because the framer overwrites them.
   function automatic logic [MAX_FRAME_WIDTH-1:0] build_fc_frame(
      input logic [7:0]  key,
      input int unsigned crc_width,
      input int unsigned frame_width
   );
      logic [MAX_FRAME_WIDTH-1:0] frame;
      frame = '0;
      frame = frame | (MAX_FRAME_WIDTH'(key) << crc_width);
      frame = frame | (MAX_FRAME_WIDTH'(META_CTRL) << (frame_width - 4));
      return frame;
   endfunction

endpackage

// File: rtl/fc_retx_timer.sv
// fc_retx_timer: refresh timer for the local FC generator (used only with FC_RETX_EN).
//   tx_frame_clk : clock
//   rst_n        : asynchronous active-low reset
//   clear_i      : synchronous clear, wins over enable
//   enable_i     : count this cycle
//   expire_o     : single-cycle pulse when an enabled count reaches INTERVAL-1
module fc_retx_timer #(
   parameter int unsigned INTERVAL = 4096
) (
   input  logic tx_frame_clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int unsigned CW = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
   localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

   logic [CW-1:0] count_q, count_d;

   assign expire_o = enable_i & (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = expire_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge tx_frame_clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/local_fc_generator.sv
// local_fc_generator: emits RIFL FC_ON / FC_OFF control frames from the local RX FIFO level,
// with hysteresis between OFF_THRESH and ON_THRESH.
//   tx_frame_clk   : clock
//   rst_n          : asynchronous active-low reset
//   link_up        : channel up; low forces the generator idle
//   rx_fifo_level  : RX FIFO occupancy
//   fc_frame       : FC frame payload (valid with fc_valid)
//   fc_valid       : frame offered to the TX framer
//   fc_ready       : framer accepts the frame
//   local_fc_state : 1 when the last accepted frame was FC_ON
// Optional macro FC_RETX_EN: periodically re-send the current key every RETX_INTERVAL cycles.
module local_fc_generator
   import rifl_fc_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH   = 256,
   parameter int unsigned CRC_WIDTH     = 12,
   parameter int unsigned CNT_WIDTH     = 10,
   parameter int unsigned ON_THRESH     = 768,
   parameter int unsigned OFF_THRESH    = 256,
   parameter int unsigned RETX_INTERVAL = 4096
) (
   input  logic                   tx_frame_clk,
   input  logic                   rst_n,
   input  logic                   link_up,
   input  logic [CNT_WIDTH-1:0]   rx_fifo_level,
   output logic [FRAME_WIDTH-1:0] fc_frame,
   output logic                   fc_valid,
   input  logic                   fc_ready,
   output logic                   local_fc_state
);

   if (OFF_THRESH >= ON_THRESH) begin : g_bad_thresh
      $error("local_fc_generator: OFF_THRESH must be below ON_THRESH");
   end
   if (RETX_INTERVAL < 2) begin : g_bad_retx
      $error("local_fc_generator: RETX_INTERVAL must be at least 2");
   end
   if ((FRAME_WIDTH > MAX_FRAME_WIDTH) || (CRC_WIDTH + 8 > FRAME_WIDTH - 4)) begin : g_bad_width
      $error("local_fc_generator: frame fields do not fit FRAME_WIDTH");
   end

   localparam logic [FRAME_WIDTH-1:0] ON_FRAME =
      FRAME_WIDTH'(build_fc_frame(FC_ON_KEY, CRC_WIDTH, FRAME_WIDTH));
   localparam logic [FRAME_WIDTH-1:0] OFF_FRAME =
      FRAME_WIDTH'(build_fc_frame(FC_OFF_KEY, CRC_WIDTH, FRAME_WIDTH));

   logic [CNT_WIDTH-1:0]   lvl_q, lvl_d;
   fc_state_e              state_q, state_d;
   logic                   fc_valid_q, fc_valid_d;
   logic [FRAME_WIDTH-1:0] fc_frame_q, fc_frame_d;
   logic                   fc_on_q, fc_on_d;

   logic handshake;
   logic lvl_high;
   logic lvl_low;
   logic retx_expire;

   assign handshake = fc_valid_q & fc_ready;
   assign lvl_high  = 32'(lvl_q) >= ON_THRESH;
   assign lvl_low   = 32'(lvl_q) <= OFF_THRESH;

`ifdef FC_RETX_EN
   logic timer_clr;
   logic timer_en;

   // Counts only in the two hold states; any state change (incl. link drop) restarts it.
   assign timer_en  = link_up & ((state_q == IDLE_OFF) | (state_q == HOLD_ON));
   assign timer_clr = ~link_up | handshake | (state_d != state_q);

   fc_retx_timer #(
      .INTERVAL (RETX_INTERVAL)
   ) u_retx_timer (
      .tx_frame_clk (tx_frame_clk),
      .rst_n        (rst_n),
      .clear_i      (timer_clr),
      .enable_i     (timer_en),
      .expire_o     (retx_expire)
   );
`else
   assign retx_expire = 1'b0;
`endif

   assign lvl_d = rx_fifo_level;

   // State register
   always_ff @(posedge tx_frame_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; threshold crossings outrank a refresh at timer expiry.
   always_comb begin
      state_d = state_q;
      if (!link_up) begin
         state_d = IDLE_OFF;
      end else begin
         unique case (state_q)
            IDLE_OFF: begin
               if (lvl_high) begin
                  state_d = SEND_ON;
               end else if (retx_expire) begin
                  state_d = SEND_OFF;
               end
            end
            SEND_ON: begin
               if (handshake) begin
                  state_d = HOLD_ON;
               end
            end
            HOLD_ON: begin
               if (lvl_low) begin
                  state_d = SEND_OFF;
               end else if (retx_expire) begin
                  state_d = SEND_ON;
               end
            end
            SEND_OFF: begin
               if (handshake) begin
                  state_d = IDLE_OFF;
               end
            end
            default: state_d = IDLE_OFF;
         endcase
      end
   end

   // Output logic: frame/valid follow the next state so they register with it and
   // stay constant for as long as the FSM waits in a SEND state.
   always_comb begin
      fc_valid_d = 1'b0;
      fc_frame_d = '0;
      unique case (state_d)
         SEND_ON: begin
            fc_valid_d = 1'b1;
            fc_frame_d = ON_FRAME;
         end
         SEND_OFF: begin
            fc_valid_d = 1'b1;
            fc_frame_d = OFF_FRAME;
         end
         default: begin
            fc_valid_d = 1'b0;
            fc_frame_d = '0;
         end
      endcase

      fc_on_d = fc_on_q;
      if (!link_up) begin
         fc_on_d = 1'b0;
      end else if (handshake) begin
         if (state_q == SEND_ON) begin
            fc_on_d = 1'b1;
         end else if (state_q == SEND_OFF) begin
            fc_on_d = 1'b0;
         end
      end
   end

   always_ff @(posedge tx_frame_clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q      <= '0;
         fc_valid_q <= 1'b0;
         fc_frame_q <= '0;
         fc_on_q    <= 1'b0;
      end else begin
         lvl_q      <= lvl_d;
         fc_valid_q <= fc_valid_d;
         fc_frame_q <= fc_frame_d;
         fc_on_q    <= fc_on_d;
      end
   end

   assign fc_valid       = fc_valid_q;
   assign fc_frame       = fc_frame_q;
   assign local_fc_state = fc_on_q;

endmodule

// File: tb/tb_local_fc_generator.sv
// tb_local_fc_generator: directed bench for local_fc_generator with a cycle model and
// hand-computed literal expectations.
module tb_local_fc_generator;

   localparam int FW    = 256;
   localparam int ON_T  = 768;
   localparam int OFF_T = 256;
   localparam int RI    = 16;
`ifdef FC_RETX_EN
   localparam bit RETX_ON = 1'b1;
`else
   localparam bit RETX_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          link_up;
   logic [9:0]    level;
   logic          fc_ready;
   logic [FW-1:0] fc_frame;
   logic          fc_valid;
   logic          local_fc_state;

   always #5 clk = ~clk;

   local_fc_generator #(
      .FRAME_WIDTH   (256),
      .CRC_WIDTH     (12),
      .CNT_WIDTH     (10),
      .ON_THRESH     (ON_T),
      .OFF_THRESH    (OFF_T),
      .RETX_INTERVAL (RI)
   ) dut (
      .tx_frame_clk   (clk),
      .rst_n          (rst_n),
      .link_up        (link_up),
      .rx_fifo_level  (level),
      .fc_frame       (fc_frame),
      .fc_valid       (fc_valid),
      .fc_ready       (fc_ready),
      .local_fc_state (local_fc_state)
   );

   int checks = 0;
   int passes = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: a pending frame (if any), whether FC is asserted, and a refresh counter.
   typedef struct packed {
      logic       pv;
      logic       on;
      logic [7:0] pk;
      int         tmr;
   } mst_t;

   mst_t m;
   int   m_lvl;

   function automatic mst_t model_step(input mst_t s, input logic link, input logic rdy,
                                       input int lvl);
      mst_t n;
      n = s;
      if (!link) begin
         n = '0;
      end else if (s.pv) begin
         if (rdy) begin
            n.on = (s.pk == 8'h01);
            n.pv = 1'b0;
         end
         n.tmr = 0;
      end else if (s.on && lvl <= OFF_T) begin
         n.pv = 1'b1; n.pk = 8'h02; n.tmr = 0;
      end else if (!s.on && lvl >= ON_T) begin
         n.pv = 1'b1; n.pk = 8'h01; n.tmr = 0;
      end else if (RETX_ON && s.tmr == RI - 1) begin
         n.pv = 1'b1; n.pk = s.on ? 8'h01 : 8'h02; n.tmr = 0;
      end else if (RETX_ON) begin
         n.tmr = s.tmr + 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m     <= '0;
         m_lvl <= 0;
      end else begin
         m     <= model_step(m, link_up, fc_ready, m_lvl);
         m_lvl <= int'(level);
      end
   end

   // Compare DUT against model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_valid", fc_valid, m.pv);
         check("model_frame", fc_frame, m.pv ? ({248'b0, m.pk} << 12) : '0);
         check("model_state", local_fc_state, m.on);
      end
   end

   // Handshake log taken from the DUT pins.
   int         cyc = 0;
   logic [7:0] hs_key[$];
   int         hs_cyc[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n === 1'b1 && fc_valid === 1'b1 && fc_ready === 1'b1) begin
         hs_key.push_back(fc_frame[19:12]);
         hs_cyc.push_back(cyc);
      end
   end

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   localparam logic [FW-1:0] ON_LIT  = 256'h1000;
   localparam logic [FW-1:0] OFF_LIT = 256'h2000;

   initial begin
      int n0;
      bit ok;
      rst_n    = 1'b0;
      link_up  = 1'b0;
      fc_ready = 1'b0;
      level    = '0;
      nclk(2);
      cmp_en = 1'b1;
      check("rst_valid", fc_valid, 0);
      check("rst_frame", fc_frame, 0);
      check("rst_state", local_fc_state, 0);
      rst_n   = 1'b1;
      link_up = 1'b1;
      nclk(1);

      // 1: level rises, ON frame two edges later, one handshake
      fc_ready = 1'b1;
      level    = 10'd800;
      nclk(1);
      check("t1_lat_early", fc_valid, 0);
      nclk(1);
      check("t1_valid", fc_valid, 1);
      check("t1_key", fc_frame[19:12], 8'h01);
      check("t1_frame", fc_frame, ON_LIT);
      n0 = hs_key.size();
      nclk(1);
      check("t1_valid_after", fc_valid, 0);
      check("t1_hs_count", hs_key.size(), n0 + 1);
      check("t1_state", local_fc_state, 1);

      // 2: back off, then ON frame held under back-pressure for 10 cycles
      level = 10'd100;
      nclk(5);
      check("t2_off_state", local_fc_state, 0);
      fc_ready = 1'b0;
      level    = 10'd800;
      nclk(2);
      check("t2_valid", fc_valid, 1);
      ok = 1'b1;
      repeat (10) begin
         nclk(1);
         if (!(fc_valid === 1'b1 && fc_frame === ON_LIT)) ok = 1'b0;
      end
      check("t2_stable", ok, 1);
      n0       = hs_key.size();
      fc_ready = 1'b1;
      nclk(1);
      check("t2_valid_after", fc_valid, 0);
      check("t2_hs_count", hs_key.size(), n0 + 1);
      check("t2_state", local_fc_state, 1);

      // 3: hysteresis band, then OFF at exactly OFF_THRESH
      n0    = hs_key.size();
      level = 10'd500;
      nclk(6);
      check("t3_no_frame", hs_key.size(), n0);
      check("t3_hold_state", local_fc_state, 1);
      level = 10'd256;
      nclk(1);
      check("t3_lat_early", fc_valid, 0);
      nclk(1);
      check("t3_valid", fc_valid, 1);
      check("t3_frame", fc_frame, OFF_LIT);
      nclk(1);
      check("t3_valid_after", fc_valid, 0);
      check("t3_state", local_fc_state, 0);

      // 4: level drops while ON is pending: ON, one idle cycle, OFF
      fc_ready = 1'b0;
      level    = 10'd800;
      nclk(2);
      check("t4_on_pending", fc_frame[19:12], 8'h01);
      level = 10'd100;
      nclk(4);
      check("t4_still_on", fc_frame, ON_LIT);
      n0       = hs_key.size();
      fc_ready = 1'b1;
      nclk(4);
      check("t4_hs_count", hs_key.size(), n0 + 2);
      if (hs_key.size() >= n0 + 2) begin
         check("t4_first_key", hs_key[n0], 8'h01);
         check("t4_second_key", hs_key[n0+1], 8'h02);
         check("t4_gap", hs_cyc[n0+1] - hs_cyc[n0], 2);
      end
      check("t4_state", local_fc_state, 0);

      // 5: held level, refresh cadence (or single frame without refresh)
      link_up = 1'b0;
      level   = 10'd800;
      nclk(2);
      n0      = hs_key.size();
      link_up = 1'b1;
      nclk(1);
      ok = 1'b1;
      repeat (60) begin
         nclk(1);
         if (hs_key.size() > n0 && local_fc_state !== 1'b1) ok = 1'b0;
      end
      check("t5_count", hs_key.size() - n0, RETX_ON ? 4 : 1);
      check("t5_state_held", ok, 1);
      for (int i = n0 + 1; i < hs_key.size(); i++) begin
         check("t5_spacing", hs_cyc[i] - hs_cyc[i-1], 17);
         check("t5_key", hs_key[i], 8'h01);
      end

      // 6: async reset mid SEND_ON, link drop in HOLD_ON, link return
      level = 10'd100;
      nclk(5);
      fc_ready = 1'b0;
      level    = 10'd800;
      nclk(2);
      check("t6_send_on", fc_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", fc_valid, 0);
      check("t6_rst_frame", fc_frame, 0);
      check("t6_rst_state", local_fc_state, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      fc_ready = 1'b1;
      nclk(4);
      check("t6_hold_on", local_fc_state, 1);
      link_up = 1'b0;
      level   = 10'd0;
      nclk(1);
      check("t6_link_state", local_fc_state, 0);
      check("t6_link_valid", fc_valid, 0);
      nclk(1);
      link_up = 1'b1;
      level   = 10'd800;
      nclk(1);
      check("t6_up_early", fc_valid, 0);
      nclk(1);
      check("t6_up_valid", fc_valid, 1);
      check("t6_up_key", fc_frame[19:12], 8'h01);
      nclk(1);
      check("t6_up_state", local_fc_state, 1);

      nclk(2);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
